// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package if_pkg;

    localparam int ILEN = 32;

    // Canonical no-op (addi x0, x0, 0) that ID can substitute for a bubble.
    localparam logic [ILEN-1:0] INST_NOP = 32'h00000013;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Request tracker: nothing in flight, in flight, in flight but stale.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DROP
    } req_state_t;

    // Redirect targets are word addresses; the low two bits are ignored.
    function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] addr);
        return {addr[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch stage's memory-side and ID-side signals.
interface fetch_queue_if;
    import if_pkg::*;

    logic            mem_req;
    logic [ILEN-1:0] mem_addr;
    logic            mem_ok;
    logic [ILEN-1:0] mem_dt;
    logic [ILEN-1:0] id_if_pc;
    logic            id_if_pce;
    logic            stl;
    logic            valid;
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] is;

    // The fetch stage itself.
    modport master (
        output mem_req, mem_addr, valid, pc, is,
        input  mem_ok, mem_dt, id_if_pc, id_if_pce, stl
    );

    // Memory controller plus ID, seen from the outside.
    modport slave (
        input  mem_req, mem_addr, valid, pc, is,
        output mem_ok, mem_dt, id_if_pc, id_if_pce, stl
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Flush wins over push and pop; pointers wrap naturally at DEPTH.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           din,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage array: data only, never needs clearing since count guards reads.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a prefetch queue. Requests are only issued
// when a queue slot is guaranteed for the response, so the queue never
// overflows. A redirect flushes the queue and marks any in-flight fetch stale.
module fetch_queue
    import if_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [ILEN-1:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    req_state_t      state;
    logic [ILEN-1:0] fetch_pc;
    logic [ILEN-1:0] req_addr;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    resp_entry;
    logic            flush;
    logic            issue;
    logic            push;
    logic            pop;
    logic            not_empty;

    assign flush      = bus.id_if_pce;
    assign not_empty  = (count != '0);

    // With nothing in flight, a free slot is all that is needed to issue.
    // A redirect cycle never issues, so the first request goes to the target.
    assign issue      = !rst && !flush && (state == IDLE) && (count < CW'(DEPTH));
    assign push       = (state == WAIT) && bus.mem_ok && !flush;
    assign pop        = not_empty && !bus.stl && !flush;
    assign resp_entry = '{pc: req_addr, inst: bus.mem_dt};

    // The controller cannot abort, so a stale request stays visible until its ok.
    assign bus.mem_req  = issue || (!rst && (state != IDLE));
    assign bus.mem_addr = (state == IDLE) ? fetch_pc : req_addr;
    assign bus.valid    = not_empty;
    assign bus.pc       = not_empty ? head.pc   : '0;
    assign bus.is       = not_empty ? head.inst : '0;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (resp_entry),
        .head  (head),
        .count (count)
    );

    // Request tracker plus the next-fetch address; redirect overrides the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (bus.mem_ok) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (bus.mem_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush) begin
                fetch_pc <= align_pc(bus.id_if_pc);
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory responder with variable latency, an ID
// side with random stalls and redirects, and a queue-based reference model.
module tb_fetch_queue;
    import if_pkg::*;

    localparam int              DEPTH    = 4;
    localparam logic [31:0]     RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the fetch stage should be doing.
    logic [31:0]  m_pc;
    logic [31:0]  m_addr;
    logic         m_out;
    logic         m_drop;
    int           m_wait;
    fetch_entry_t m_q[$];

    // Memory responder knobs.
    int           lat_min;
    int           lat_max;
    logic         force_ok;
    logic         ok_now;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F13};
    endfunction

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_addr = RESET_PC;
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_wait = 0;
        m_q.delete();
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_bound(input string tag, input int n);
        total++;
        assert (n < 60) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d cycles expected=<60", tag, n);
        end
    endtask

    task automatic checkOutput(input logic r, input logic p);
        logic        exp_valid;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_is;
        exp_valid = (m_q.size() != 0);
        exp_pc    = exp_valid ? m_q[0].pc   : 32'h0;
        exp_is    = exp_valid ? m_q[0].inst : 32'h0;
        exp_req   = !r && (m_out || ((m_q.size() < DEPTH) && !p));
        exp_addr  = m_out ? m_addr : m_pc;
        check32("valid",   {31'b0, bus.valid},   {31'b0, exp_valid});
        check32("pc",      bus.pc,               exp_pc);
        check32("is",      bus.is,               exp_is);
        check32("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
        if (exp_req || r) begin
            check32("mem_addr", bus.mem_addr, exp_addr);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic r, input logic s, input logic p, input logic [31:0] tgt);
        logic         issue;
        logic         resp;
        logic         do_push;
        fetch_entry_t e;
        @(negedge clk);
        rst           = r;
        bus.stl       = s;
        bus.id_if_pce = p;
        bus.id_if_pc  = p ? tgt : $urandom;
        ok_now        = (force_ok || (m_out && m_wait == 0)) && !r;
        bus.mem_ok    = ok_now;
        bus.mem_dt    = (ok_now && m_out) ? inst_of(m_addr) : $urandom;
        #1 checkOutput(r, p);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            issue   = !m_out && (m_q.size() < DEPTH) && !p;
            resp    = ok_now && m_out;
            do_push = 1'b0;
            e.pc    = m_addr;
            e.inst  = inst_of(m_addr);
            if (resp) begin
                do_push = !m_drop && !p;
                m_out   = 1'b0;
                m_drop  = 1'b0;
            end else if (m_out) begin
                if (p) m_drop = 1'b1;
                if (m_wait > 0) m_wait--;
            end
            if (p) begin
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && !s) void'(m_q.pop_front());
                if (do_push) m_q.push_back(e);
            end
            if (p) begin
                m_pc = {tgt[31:2], 2'b00};
            end else if (issue) begin
                m_out  = 1'b1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
                m_wait = $urandom_range(lat_max, lat_min);
            end
        end
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.stl       = 1'b0;
        bus.id_if_pce = 1'b0;
        bus.id_if_pc  = 32'h0;
        bus.mem_ok    = 1'b0;
        bus.mem_dt    = 32'h0;
        force_ok      = 1'b0;
        ok_now        = 1'b0;
        lat_min       = 0;
        lat_max       = 0;
        model_reset();
        @(posedge clk);

        $display("[TB] reset values");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);

        $display("[TB] streaming with a 1-cycle memory");
        repeat (24) applyStimulus(0, 0, 0, 0);

        $display("[TB] stall held until the queue fills");
        repeat (20) applyStimulus(0, 1, 0, 0);
        repeat (12) applyStimulus(0, 0, 0, 0);

        $display("[TB] redirect while a request is outstanding");
        lat_min = 2;
        lat_max = 2;
        n = 0;
        while (!(m_out && m_wait == 2) && n < 60) begin
            applyStimulus(0, 0, 0, 0);
            n++;
        end
        check_bound("wait_outstanding", n);
        applyStimulus(0, 0, 1, 32'h100);
        repeat (12) applyStimulus(0, 0, 0, 0);

        $display("[TB] redirect coinciding with mem_ok");
        lat_min = 0;
        lat_max = 0;
        n = 0;
        while (!(m_out && m_wait == 0) && n < 60) begin
            applyStimulus(0, 0, 0, 0);
            n++;
        end
        check_bound("wait_ok_cycle", n);
        applyStimulus(0, 0, 1, 32'h203);
        repeat (8) applyStimulus(0, 0, 0, 0);

        $display("[TB] redirect with the queue full and no stall");
        n = 0;
        while (!(m_q.size() == DEPTH && !m_out) && n < 60) begin
            applyStimulus(0, 1, 0, 0);
            n++;
        end
        check_bound("fill_for_redirect", n);
        applyStimulus(0, 0, 1, 32'h40);
        repeat (6) applyStimulus(0, 0, 0, 0);

        $display("[TB] stray mem_ok with nothing outstanding");
        n = 0;
        while (!(m_q.size() == DEPTH && !m_out) && n < 60) begin
            applyStimulus(0, 1, 0, 0);
            n++;
        end
        check_bound("fill_for_stray", n);
        force_ok = 1'b1;
        applyStimulus(0, 1, 0, 0);
        force_ok = 1'b0;
        repeat (3) applyStimulus(0, 1, 0, 0);

        $display("[TB] reset mid-request with two entries queued");
        applyStimulus(0, 1, 1, 32'h300);
        lat_min = 1;
        lat_max = 1;
        n = 0;
        while (!(m_q.size() == 2 && m_out) && n < 60) begin
            applyStimulus(0, 1, 0, 0);
            n++;
        end
        check_bound("two_entries", n);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        lat_min = 0;
        lat_max = 0;
        repeat (12) applyStimulus(0, 0, 0, 0);

        $display("[TB] random traffic");
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(99, 0) == 0),
                          ($urandom_range(3, 0) == 0),
                          ($urandom_range(15, 0) == 0),
                          $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
